// File: rtl/isqrt_seq.sv
// Sequential digit-by-digit integer square root: one root bit per cycle,
// valid/ready on both sides, optional round-to-nearest on the root output.
module isqrt_seq #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 9,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  radicand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] root,
  output logic [OUT_W:0]   remainder,
  output logic             busy
);

  localparam int PAD_W = 2 * OUT_W;
  localparam int REM_W = OUT_W + 2;
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [PAD_W-1:0]   rad_q, rad_d;
  logic [OUT_W-1:0]   part_q, part_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   root_q, root_d;
  logic [OUT_W:0]     rem_out_q, rem_out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [REM_W-1:0]   rem_shift;
  logic [REM_W-1:0]   trial;
  logic               fits;
  logic [REM_W-1:0]   rem_next;
  logic [OUT_W-1:0]   part_next;
  logic               round_up;

  // One iteration: bring down the next radicand bit pair and trial-subtract 4r+1.
  always_comb begin
    rem_shift = REM_W'({rem_q, rad_q[PAD_W-1 -: 2]});
    trial     = REM_W'({part_q, 2'b01});
    fits      = (rem_shift >= trial);
    rem_next  = fits ? (rem_shift - trial) : rem_shift;
    part_next = (part_q << 1) | OUT_W'(fits);
    round_up  = (ROUND != 0) && (rem_next > REM_W'(part_next)) && (part_next != '1);
  end

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    part_d      = part_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    root_d      = root_q;
    rem_out_d   = rem_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rad_d      = PAD_W'(radicand);
          part_d     = '0;
          rem_d      = '0;
          cnt_d      = CNT_W'(OUT_W - 1);
          state_d    = CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      CALC: begin
        rad_d  = rad_q << 2;
        part_d = part_next;
        rem_d  = rem_next;
        if (cnt_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          root_d      = round_up ? (part_next + OUT_W'(1)) : part_next;
          rem_out_d   = (OUT_W + 1)'(rem_next);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // The output handshake wins; a new radicand waits for the next IDLE edge.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rad_q       <= '0;
      part_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      root_q      <= '0;
      rem_out_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      part_q      <= part_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      root_q      <= root_d;
      rem_out_q   <= rem_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign root      = root_q;
  assign remainder = rem_out_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Scoreboard bench for isqrt_seq: a floor-root and a rounding instance run in
// lockstep; stimulus pushes expected results, a negedge monitor pops and compares.
module tb_isqrt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [16:0] radicand = '0;

  logic        in_ready, out_valid, busy;
  logic [8:0]  root;
  logic [9:0]  remainder;
  logic        in_ready_r, out_valid_r, busy_r;
  logic [8:0]  root_r;
  logic [9:0]  remainder_r;

  typedef struct {
    logic [16:0] rad;
    logic [8:0]  root;
    logic [9:0]  rem;
  } exp_t;

  exp_t exp_q[$];
  exp_t rnd_q[$];
  exp_t e_mon, e_mon_r;

  int checks = 0;
  int failures = 0;
  int issued = 0;
  int received = 0;
  bit rand_ready = 1'b0;
  bit watch_valid = 1'b0;
  bit pulsed = 1'b0;

  isqrt_seq #(.IN_W(17), .OUT_W(9), .ROUND(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .radicand(radicand), .out_valid(out_valid), .out_ready(out_ready),
    .root(root), .remainder(remainder), .busy(busy)
  );

  isqrt_seq #(.IN_W(17), .OUT_W(9), .ROUND(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .radicand(radicand), .out_valid(out_valid_r), .out_ready(out_ready),
    .root(root_r), .remainder(remainder_r), .busy(busy_r)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_sqrt(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  task automatic applyStimulus(input int rad, input int e_root, input int e_rem,
                               input int e_rnd, output int waited);
    exp_t e;
    in_valid = 1'b1;
    radicand = 17'(rad);
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.rad = 17'(rad); e.root = 9'(e_root); e.rem = 10'(e_rem);
      exp_q.push_back(e);
      e.root = 9'(e_rnd);
      rnd_q.push_back(e);
      issued++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    radicand = 17'($urandom);
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || rnd_q.size() != 0) && b < 500) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (exp_q.size() != 0 || rnd_q.size() != 0)
      checkOutput("drain_timeout", 32'(exp_q.size() + rnd_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      received++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_output", 32'(exp_q.size()), 32'd1);
      end else begin
        e_mon = exp_q.pop_front();
        checkOutput("root", 32'(root), 32'(e_mon.root));
        checkOutput("remainder", 32'(remainder), 32'(e_mon.rem));
        checkOutput("identity", 32'(root) * 32'(root) + 32'(remainder), 32'(e_mon.rad));
      end
    end
    if (rst_n && out_valid_r && out_ready) begin
      if (rnd_q.size() == 0) begin
        checkOutput("spurious_output_round", 32'(rnd_q.size()), 32'd1);
      end else begin
        e_mon_r = rnd_q.pop_front();
        checkOutput("root_round", 32'(root_r), 32'(e_mon_r.root));
        checkOutput("remainder_round", 32'(remainder_r), 32'(e_mon_r.rem));
      end
    end
    if (watch_valid && (out_valid || out_valid_r)) pulsed = 1'b1;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int d_rad  [7] = '{625, 325, 100, 0, 131071, 110, 111};
    int d_root [7] = '{25, 18, 10, 0, 362, 10, 10};
    int d_rem  [7] = '{0, 1, 0, 0, 27, 10, 11};
    int d_rnd  [7] = '{25, 18, 10, 0, 362, 10, 11};
    int waited, cyc, x, y, n, r, rm, rr;
    bit low_ok;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_root", 32'(root), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] latency: 25");
    out_ready = 1'b1;
    applyStimulus(25, 5, 0, 5, waited);
    cyc = 0;
    low_ok = 1'b1;
    while (!out_valid && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
      if (in_ready) low_ok = 1'b0;
    end
    checkOutput("latency", 32'(cyc), 32'd9);
    checkOutput("in_ready_low_calc", 32'(low_ok), 32'd1);
    drain();

    $display("[TB] directed sequence");
    for (int i = 0; i < 7; i++)
      applyStimulus(d_rad[i], d_root[i], d_rem[i], d_rnd[i], waited);
    drain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(625, 25, 0, 25, waited);
    in_valid = 1'b1;
    radicand = 17'd7;
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("stall_root", 32'(root), 32'd25);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(7, 2, 3, 3, waited);
    checkOutput("accept_after_handshake", 32'(waited), 32'd1);
    drain();

    $display("[TB] reset mid-calc");
    applyStimulus(625, 25, 0, 25, waited);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    rnd_q.delete();
    issued--;
    watch_valid = 1'b1;
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_root", 32'(root), 32'd0);
    checkOutput("midreset_remainder", 32'(remainder), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("no_valid_after_reset", 32'(pulsed), 32'd0);
    watch_valid = 1'b0;
    applyStimulus(100, 10, 0, 10, waited);
    drain();

    $display("[TB] random sweep");
    rand_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      x  = $urandom_range(0, 255);
      y  = $urandom_range(0, 255);
      n  = x * x + y * y;
      r  = floor_sqrt(n);
      rm = n - r * r;
      rr = (rm > r && r != 511) ? r + 1 : r;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(n, r, rm, rr, waited);
    end
    @(posedge clk);
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    drain();

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("in_out_count", 32'(received), 32'(issued));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
